traffic_light_ctrl_n: RTL and testbench
=======================================

// Module: traffic_light_ctrl_n
// PURPOSE
//  Parametrised N-way intersection controller; successor of the 2-way sensor-driven light FSM.
//  Grants green to one approach at a time with timed green, yellow and all-red phases.
//  Phase lengths are counted in `tick` pulses from a shared prescaler; requests come from per-approach sensors.
//  The next green is chosen round-robin among requesting approaches.
//  Sits between the board sensor inputs and the lamp/LED driver.
// PARAMETERS
//  NUM_DIR    4   number of approaches, 2..8
//  GREEN_MIN  3   minimum green length, ticks, >=1
//  GREEN_MAX  6   maximum green length when another approach requests, ticks, >=GREEN_MIN
//  YELLOW_T   2   yellow length, ticks, >=1
//  ALLRED_T   1   all-red clearance length, ticks, >=1
//  WALK_T     4   pedestrian walk length, ticks; used only with PED_WALK_EN
//  CNT_W      8   phase counter width; must hold max(GREEN_MAX, YELLOW_T, ALLRED_T, WALK_T)
// PORTS
//  clk         in   1                  clock
//  reset       in   1                  asynchronous, active-high
//  tick        in   1                  phase-time enable, 1-cycle pulse or held high
//  sensor      in   NUM_DIR            bit i = vehicle waiting on approach i
//  light       out  2*NUM_DIR          bits [2i+1:2i] = approach i lamp: 00 red, 01 yellow, 10 green
//  active_dir  out  $clog2(NUM_DIR)    approach currently owning green/yellow
//  phase       out  2                  00 GREEN, 01 YELLOW, 10 ALLRED, 11 WALK
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-phase): phase=GREEN, active_dir=0, cnt=0, light=approach 0 green, all others red.
//  - All state is registered. light, active_dir and phase decode from state regs, with no extra latency.
//  - cnt counts ticks spent in the current phase. It advances only on cycles with tick=1 and clears on every phase change.
//  - A phase of length T ends on the tick where cnt==T-1, so it lasts exactly T ticks.
//  - Define others = |(sensor & ~onehot(active_dir)).
//  - GREEN -> YELLOW on a tick when:
//      (cnt>=GREEN_MIN-1 && !sensor[active_dir] && others)
//      || (cnt>=GREEN_MAX-1 && others).
//  - GREEN with others=0: stays GREEN indefinitely. cnt saturates at GREEN_MAX-1 and does not wrap.
//  - On GREEN exit, next_dir is latched: the first i with sensor[i]=1, scanning active_dir+1, +2, ... modulo NUM_DIR (wrap-around).
//  - Sensor changes during YELLOW or ALLRED do not alter the latched next_dir.
//  - YELLOW: light[active_dir]=01. After YELLOW_T ticks -> ALLRED.
//  - ALLRED: all lamps red. After ALLRED_T ticks -> GREEN with active_dir=next_dir.
//  - active_dir keeps the old approach through YELLOW and ALLRED, and updates on GREEN entry.
//  - tick held high: one count per clk. tick=0: FSM frozen, outputs stable.
//  - Exactly one approach is non-red at any time. No green-to-green transition is allowed without YELLOW and ALLRED between.
// CONFIGURATION
//  - PED_WALK_EN defined:
//      - Adds ports ped_req (in, 1) and walk (out, 1).
//      - A ped_req pulse sets a sticky ped_pending flag in any phase except WALK.
//      - At ALLRED end, if ped_pending=1: go to WALK. ped_pending clears on WALK entry.
//      - WALK: all lamps red, walk=1, lasts WALK_T ticks, then GREEN with next_dir.
//      - walk=0 in every other phase. Reset clears ped_pending and walk.
//  - PED_WALK_EN undefined:
//      - No ped_req/walk ports.
//      - WALK phase encoding 11 is unreachable. ALLRED always proceeds to GREEN.
// TESTING
//  Defaults; tick=1 every cycle unless stated.
//  1. Release reset, sensor=4'b0000 for 20 cycles -> light=8'b00000010, phase=00, active_dir=0 throughout.
//  2. sensor=4'b0100 from reset -> approach 0 green 3 cycles, yellow 2, all-red 1; then light=8'b00100000, active_dir=2.
//  3. sensor=4'b0011 held -> approach 0 green 6 cycles (GREEN_MAX), then yellow/all-red, then approach 1 green.
//  4. Active_dir=3, sensor=4'b1001 -> after GREEN_MAX, next green is approach 0 (wrap-around).
//  5. tick every 4th cycle, sensor=4'b0010 -> durations x4: green 12, yellow 8, all-red 4 cycles.
//     Then assert reset mid-YELLOW -> same cycle: light=8'b00000010, phase=00.
//  6. PED_WALK_EN, sensor=4'b0010, 1-cycle ped_req during GREEN -> after all-red, walk=1 and all red for 4 cycles.
//     Then approach 1 green, walk=0.

Source files
------------

// File: rtl/traffic_light_ctrl_n.sv
// traffic_light_ctrl_n: N-way round-robin intersection light controller with tick-timed green/yellow/all-red phases.
// Define PED_WALK_EN to add the ped_req/walk pedestrian phase after all-red.
module traffic_light_ctrl_n #(
  parameter int NUM_DIR = 4,
  parameter int GREEN_MIN = 3,
  parameter int GREEN_MAX = 6,
  parameter int YELLOW_T = 2,
  parameter int ALLRED_T = 1,
  parameter int WALK_T = 4,
  parameter int CNT_W = 8,
  localparam int DW = $clog2(NUM_DIR)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [NUM_DIR-1:0]   sensor,
`ifdef PED_WALK_EN
  input  logic                 ped_req,
  output logic                 walk,
`endif
  output logic [2*NUM_DIR-1:0] light,
  output logic [DW-1:0]        active_dir,
  output logic [1:0]           phase
);
  typedef enum logic [1:0] {GREEN = 2'b00, YELLOW = 2'b01, ALLRED = 2'b10, WALK = 2'b11} phase_t;
  phase_t phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dir_q, dir_d, next_q, next_d, scan, idx;
  logic others, go_yellow, last, ped_go;
  always_comb begin
    scan = dir_q;
    idx = dir_q;
    for (int k = NUM_DIR - 1; k >= 1; k--) begin
      idx = DW'((int'(dir_q) + k) % NUM_DIR);
      if (sensor[idx]) scan = idx;
    end
  end
  assign others = |(sensor & ~(NUM_DIR'(1) << dir_q));
  assign go_yellow = phase_q == GREEN && others &&
                     (cnt_q >= CNT_W'(GREEN_MAX - 1) || (cnt_q >= CNT_W'(GREEN_MIN - 1) && !sensor[dir_q]));
  assign last = cnt_q == (phase_q == YELLOW ? CNT_W'(YELLOW_T - 1) :
                          phase_q == ALLRED ? CNT_W'(ALLRED_T - 1) : CNT_W'(WALK_T - 1));
  // Green count saturates so an uncontested green never wraps back below GREEN_MIN.
  always_comb begin
    phase_d = phase_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
    next_d = next_q;
    if (tick) begin
      cnt_d = (phase_q == GREEN && cnt_q >= CNT_W'(GREEN_MAX - 1)) ? cnt_q : cnt_q + 1'b1;
      if (go_yellow) begin
        phase_d = YELLOW;
        cnt_d = '0;
        next_d = scan;
      end else if (phase_q != GREEN && last) begin
        cnt_d = '0;
        phase_d = phase_q == YELLOW ? ALLRED : (phase_q == ALLRED && ped_go) ? WALK : GREEN;
        dir_d = phase_d == GREEN ? next_q : dir_q;
      end
    end
  end
`ifdef PED_WALK_EN
  logic ped_q, ped_d;
  assign ped_d = (phase_d == WALK && phase_q != WALK) ? 1'b0 : ped_q | (ped_req && phase_q != WALK);
  assign ped_go = ped_q;
  assign walk = phase_q == WALK;
`else
  assign ped_go = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= GREEN;
      cnt_q <= '0;
      dir_q <= '0;
      next_q <= '0;
`ifdef PED_WALK_EN
      ped_q <= 1'b0;
`endif
    end else begin
      phase_q <= phase_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      next_q <= next_d;
`ifdef PED_WALK_EN
      ped_q <= ped_d;
`endif
    end
  end
  for (genvar i = 0; i < NUM_DIR; i++) begin : g_lamp
    assign light[2*i+:2] = dir_q != DW'(i) ? 2'b00 :
                           phase_q == GREEN ? 2'b10 : phase_q == YELLOW ? 2'b01 : 2'b00;
  end
  assign active_dir = dir_q;
  assign phase = phase_q;
endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
// tb_traffic_light_ctrl_n: directed checks of phase timing, round-robin selection, tick gating and async reset.
module tb_traffic_light_ctrl_n;
  logic clk, reset, tick, ped_req, walk;
  logic [3:0] sensor;
  logic [7:0] light;
  logic [1:0] active_dir, phase;
  int per, ph, compared, mismatched;

  traffic_light_ctrl_n dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .sensor(sensor),
`ifdef PED_WALK_EN
    .ped_req(ped_req),
    .walk(walk),
`endif
    .light(light),
    .active_dir(active_dir),
    .phase(phase)
  );
`ifndef PED_WALK_EN
  assign walk = 1'b0;
`endif

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    tick = (ph % per) == per - 1;
    ph++;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] el, input logic [1:0] ep,
                       input logic [1:0] ed, input logic ew);
    compared++;
    assert ({light, phase, active_dir, walk} === {el, ep, ed, ew}) else begin
      mismatched++;
      $error("FAIL %s: light=%b phase=%b dir=%0d walk=%b, expected light=%b phase=%b dir=%0d walk=%b",
             tag, light, phase, active_dir, walk, el, ep, ed, ew);
    end
  endtask

  task automatic expect_n(input int n, input string tag, input logic [7:0] el, input logic [1:0] ep,
                          input logic [1:0] ed, input logic ew);
    for (int i = 0; i < n; i++) begin
      step();
      check(tag, el, ep, ed, ew);
    end
  endtask

  task automatic do_reset(input string tag, input logic [3:0] s);
    sensor = s;
    reset = 1;
    #1;
    check(tag, 8'b00000010, 2'b00, 2'd0, 1'b0);
    @(negedge clk);
    reset = 0;
    ph = 0;
  endtask

  initial begin
    reset = 0; tick = 1; sensor = 0; ped_req = 0;
    per = 1; ph = 0; compared = 0; mismatched = 0;
    do_reset("rst_idle", 4'b0000);
    expect_n(20, "idle_hold", 8'b00000010, 2'b00, 2'd0, 1'b0);

    do_reset("rst_min", 4'b0100);
    expect_n(2, "min_green0", 8'b00000010, 2'b00, 2'd0, 1'b0);
    expect_n(2, "min_yellow0", 8'b00000001, 2'b01, 2'd0, 1'b0);
    expect_n(1, "min_allred", 8'b00000000, 2'b10, 2'd0, 1'b0);
    expect_n(1, "min_green2", 8'b00100000, 2'b00, 2'd2, 1'b0);
    expect_n(8, "uncontested_hold2", 8'b00100000, 2'b00, 2'd2, 1'b0);
    sensor = 4'b0001;
    expect_n(1, "saturated_exit", 8'b00010000, 2'b01, 2'd2, 1'b0);

    do_reset("rst_max", 4'b0011);
    expect_n(5, "max_green0", 8'b00000010, 2'b00, 2'd0, 1'b0);
    expect_n(2, "max_yellow0", 8'b00000001, 2'b01, 2'd0, 1'b0);
    expect_n(1, "max_allred", 8'b00000000, 2'b10, 2'd0, 1'b0);
    expect_n(1, "max_green1", 8'b00001000, 2'b00, 2'd1, 1'b0);

    do_reset("rst_wrap", 4'b1000);
    expect_n(2, "wrap_green0", 8'b00000010, 2'b00, 2'd0, 1'b0);
    expect_n(2, "wrap_yellow0", 8'b00000001, 2'b01, 2'd0, 1'b0);
    expect_n(1, "wrap_allred0", 8'b00000000, 2'b10, 2'd0, 1'b0);
    expect_n(1, "wrap_green3", 8'b10000000, 2'b00, 2'd3, 1'b0);
    sensor = 4'b1001;
    expect_n(5, "wrap_hold3", 8'b10000000, 2'b00, 2'd3, 1'b0);
    expect_n(2, "wrap_yellow3", 8'b01000000, 2'b01, 2'd3, 1'b0);
    expect_n(1, "wrap_allred3", 8'b00000000, 2'b10, 2'd3, 1'b0);
    expect_n(1, "wrap_green0_again", 8'b00000010, 2'b00, 2'd0, 1'b0);

    per = 4;
    do_reset("rst_tick4", 4'b0010);
    expect_n(11, "tick4_green0", 8'b00000010, 2'b00, 2'd0, 1'b0);
    expect_n(8, "tick4_yellow0", 8'b00000001, 2'b01, 2'd0, 1'b0);
    expect_n(4, "tick4_allred", 8'b00000000, 2'b10, 2'd0, 1'b0);
    expect_n(1, "tick4_green1", 8'b00001000, 2'b00, 2'd1, 1'b0);
    do_reset("rst_tick4b", 4'b0010);
    expect_n(11, "tick4b_green0", 8'b00000010, 2'b00, 2'd0, 1'b0);
    expect_n(4, "tick4b_yellow0", 8'b00000001, 2'b01, 2'd0, 1'b0);
    #2;
    do_reset("async_rst_mid_yellow", 4'b0010);
    per = 1;
    expect_n(2, "post_rst_green0", 8'b00000010, 2'b00, 2'd0, 1'b0);
    expect_n(1, "post_rst_yellow0", 8'b00000001, 2'b01, 2'd0, 1'b0);

`ifdef PED_WALK_EN
    do_reset("rst_ped", 4'b0010);
    ped_req = 1;
    expect_n(1, "ped_green0a", 8'b00000010, 2'b00, 2'd0, 1'b0);
    ped_req = 0;
    expect_n(1, "ped_green0b", 8'b00000010, 2'b00, 2'd0, 1'b0);
    expect_n(2, "ped_yellow0", 8'b00000001, 2'b01, 2'd0, 1'b0);
    expect_n(1, "ped_allred", 8'b00000000, 2'b10, 2'd0, 1'b0);
    expect_n(4, "ped_walk", 8'b00000000, 2'b11, 2'd0, 1'b1);
    expect_n(1, "ped_green1", 8'b00001000, 2'b00, 2'd1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
